// File: rtl/fifo_reader_if.sv
// fifo_reader_if: FIFO read port plus the downstream valid/ready stream.
interface fifo_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic                  fifo_underflow;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  rd;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    modport master(
        input  fifo_empty, fifo_underflow, fifo_data, m_ready,
        output rd, m_data, m_valid
    );
    modport slave(
        output fifo_empty, fifo_underflow, fifo_data, m_ready,
        input  rd, m_data, m_valid
    );
endinterface

// File: rtl/fifo_reader.sv
// fifo_reader: fetches words from fifo_memory into a 2-entry skid buffer and streams them out.
module fifo_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    fifo_reader_if.master        bus,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] rd_count,
    output logic                 err_underflow
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
    state_t                state;
    logic [DATA_WIDTH-1:0] buf0, buf1;
    logic [1:0]            occ;
    logic                  inflight;
    logic                  pop;
    logic [1:0]            left;
    logic [2:0]            room;
    // Slots committed next cycle: survivors after pop plus the word already in flight.
    always_comb begin
        pop    = bus.m_valid & bus.m_ready;
        left   = occ - {1'b0, pop};
        room   = {1'b0, left} + {2'b0, inflight};
        bus.rd = (state == FETCH) & ~bus.fifo_empty & ~rst & (room < 3'd2);
    end
    assign bus.m_valid = occ != 2'd0;
    assign bus.m_data  = buf0;
    assign busy        = state != IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            occ           <= 2'd0;
            inflight      <= 1'b0;
            buf0          <= '0;
            buf1          <= '0;
            rd_count      <= '0;
            err_underflow <= 1'b0;
        end else begin
            inflight <= bus.rd;
            occ      <= left + {1'b0, inflight};
            rd_count <= rd_count + CNT_WIDTH'(inflight);
            if (inflight & bus.fifo_underflow) err_underflow <= 1'b1;
            if (pop) buf0 <= buf1;
            // The arriving word lands behind whatever survives this cycle's pop.
            if (inflight) begin
                if (left == 2'd0) buf0 <= bus.fifo_data;
                else buf1 <= bus.fifo_data;
            end
            state <= state == IDLE  ? (enable ? FETCH : IDLE) :
                     state == FETCH ? (enable ? FETCH : DRAIN) :
                     enable ? FETCH :
                     (occ == 2'd0 && !inflight) ? IDLE : DRAIN;
        end
    end
endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: directed bench with a FIFO model and an expected-word scoreboard.
module tb_fifo_reader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        busy;
    logic [15:0] rd_count;
    logic        err_underflow;
    fifo_reader_if #(.DATA_WIDTH(8)) bus();
    fifo_reader #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .bus(bus.master),
        .busy(busy), .rd_count(rd_count), .err_underflow(err_underflow)
    );
    always #5 clk = ~clk;
    int n_cmp = 0, n_bad = 0, cyc = 0, guard;
    int rd_pulses, n_pops, first_rd, last_rd, first_pop, last_pop;
    logic [7:0] fq[$];
    logic [7:0] sbq[$];
    logic       force_uf = 1'b0;
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    task automatic clr();
        rd_pulses = 0; n_pops = 0;
        first_rd = -1; last_rd = -1; first_pop = -1; last_pop = -1;
    endtask
    task automatic load(int first, int n, int n_sb);
        for (int i = 0; i < n; i++) begin
            fq.push_back(8'(first + i));
            if (i < n_sb) sbq.push_back(8'(first + i));
        end
        bus.fifo_empty = fq.size() == 0;
    endtask
    // One clock: sample mid-cycle, then model fifo_memory's registered data_out.
    task automatic cycle();
        logic       r;
        logic [7:0] exp_w;
        @(negedge clk);
        r = bus.rd;
        if (r) begin
            rd_pulses++; last_rd = cyc;
            if (first_rd < 0) first_rd = cyc;
        end
        if (bus.m_valid && bus.m_ready) begin
            n_pops++; last_pop = cyc;
            if (first_pop < 0) first_pop = cyc;
            chk("pop_expected", 32'(sbq.size() != 0), 1);
            if (sbq.size() != 0) begin
                exp_w = sbq.pop_front();
                chk("m_data", 32'(bus.m_data), 32'(exp_w));
            end
        end
        cyc++;
        @(posedge clk);
        #1;
        bus.fifo_underflow = r & force_uf;
        if (r && fq.size() != 0) bus.fifo_data = fq.pop_front();
        bus.fifo_empty = fq.size() == 0;
    endtask
    initial begin
        bus.fifo_empty = 1'b1; bus.fifo_underflow = 1'b0;
        bus.fifo_data = 8'd0; bus.m_ready = 1'b0;
        enable = 1'b1;
        cycle(); cycle();
        chk("rd_in_rst", 32'(bus.rd), 0);
        rst = 1'b0;
        chk("rst_m_valid", 32'(bus.m_valid), 0);
        chk("rst_m_data", 32'(bus.m_data), 0);
        chk("rst_rd_count", 32'(rd_count), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err_underflow), 0);
        clr();
        repeat (4) cycle();
        chk("empty_no_rd", rd_pulses, 0);
        chk("empty_busy", 32'(busy), 1);
        // Four preloaded words streamed at full rate.
        clr();
        bus.m_ready = 1'b1;
        load(1, 4, 4);
        guard = 0;
        while (sbq.size() != 0 && guard < 20) begin cycle(); guard++; end
        chk("p2_drained", sbq.size(), 0);
        chk("p2_rd_pulses", rd_pulses, 4);
        chk("p2_rd_back2back", last_rd - first_rd, 3);
        chk("p2_latency", first_pop - first_rd, 2);
        chk("p2_pop_back2back", last_pop - first_pop, 3);
        chk("p2_rd_count", 32'(rd_count), 4);
        // Backpressure fills the buffer, release drains 16 words without gaps.
        rst = 1'b1; cycle(); rst = 1'b0;
        clr();
        bus.m_ready = 1'b0;
        load(1, 16, 16);
        repeat (10) cycle();
        chk("p3_rd_pulses_held", rd_pulses, 2);
        chk("p3_m_valid_held", 32'(bus.m_valid), 1);
        chk("p3_m_data_held", 32'(bus.m_data), 1);
        chk("p3_no_pops", n_pops, 0);
        bus.m_ready = 1'b1;
        guard = 0;
        while (sbq.size() != 0 && guard < 60) begin cycle(); guard++; end
        chk("p3_drained", sbq.size(), 0);
        chk("p3_pops", n_pops, 16);
        chk("p3_no_gaps", last_pop - first_pop, 15);
        chk("p3_rd_count", 32'(rd_count), 16);
        // enable drops in the very cycle word 5 is read.
        clr();
        load(101, 8, 5);
        for (int i = 0; i < 30; i++) begin
            if (fq.size() == 4) enable = 1'b0;
            cycle();
            if (!busy && sbq.size() == 0) break;
        end
        chk("p4_pops", n_pops, 5);
        chk("p4_sb_empty", sbq.size(), 0);
        chk("p4_fifo_kept", fq.size(), 3);
        chk("p4_rd_pulses", rd_pulses, 5);
        chk("p4_busy", 32'(busy), 0);
        chk("p4_m_valid", 32'(bus.m_valid), 0);
        chk("p4_rd_count", 32'(rd_count), 21);
        fq.delete();
        bus.fifo_empty = 1'b1;
        // Underflow after a read is sticky, the word is still delivered.
        chk("p5_err_pre", 32'(err_underflow), 0);
        clr();
        enable = 1'b1;
        force_uf = 1'b1;
        load(55, 1, 1);
        guard = 0;
        while (sbq.size() != 0 && guard < 20) begin cycle(); guard++; end
        force_uf = 1'b0;
        chk("p5_pops", n_pops, 1);
        chk("p5_err_set", 32'(err_underflow), 1);
        repeat (3) cycle();
        enable = 1'b0;
        repeat (4) cycle();
        chk("p5_idle", 32'(busy), 0);
        chk("p5_err_sticky", 32'(err_underflow), 1);
        // Reset with a buffered word and another in flight discards both.
        clr();
        bus.m_ready = 1'b0;
        enable = 1'b1;
        load(201, 3, 0);
        guard = 0;
        while (rd_pulses < 2 && guard < 10) begin cycle(); guard++; end
        chk("p6_rd_pulses", rd_pulses, 2);
        chk("p6_m_valid_pre", 32'(bus.m_valid), 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        enable = 1'b0;
        chk("p6_m_valid", 32'(bus.m_valid), 0);
        chk("p6_rd_count", 32'(rd_count), 0);
        chk("p6_busy", 32'(busy), 0);
        chk("p6_err_clr", 32'(err_underflow), 0);
        repeat (3) cycle();
        chk("p6_no_capture", 32'(bus.m_valid), 0);
        chk("p6_rd_count_after", 32'(rd_count), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
